// File: rtl/mul_par.sv
// mul_par: sequential unsigned shift-and-add multiplier.
// Two W-bit operands are captured on an accepted start. The 2W-bit product
// appears in p after exactly W iteration cycles. Every output is registered.
// Operands are accepted in IDLE or DONE, and starts that arrive during RUN
// are ignored.
module mul_par #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic [2*W-1:0]   p,
  output logic             busy,
  output logic             valid
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // This is the count value of the final (W-th) iteration.
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] areg_q,  areg_d;
  logic [W-1:0]   breg_q,  breg_d;
  logic [2*W-1:0] acc_q,   acc_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [2*W-1:0] p_q,     p_d;
  logic           busy_q,  busy_d;
  logic           valid_q, valid_d;
  logic [2*W-1:0] acc_next;

  // Next-state logic: accept operands, iterate one partial product per cycle, and publish the result.
  always_comb begin
    state_d  = state_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    // The partial product is added only when the current multiplier LSB is set.
    // A 2W-bit sum cannot overflow for W-bit operands.
    acc_next = acc_q + (breg_q[0] ? areg_q : '0);

    case (state_q)
      S_IDLE, S_DONE: begin
        // p keeps the last product until a new result replaces it.
        if (start) begin
          areg_d  = {{W{1'b0}}, A};
          breg_d  = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      S_RUN: begin
        // Inputs are ignored here. The iteration count does not depend on the
        // operand data, so zero operands still take W cycles.
        areg_d = areg_q << 1;
        breg_d = breg_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        acc_d  = acc_next;
        if (cnt_q == CNT_LAST) begin
          p_d     = acc_next;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers: an asynchronous active-low reset aborts any operation and clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign p     = p_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule
